// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: sequences MEM-stage loads/stores onto a single-port
// synchronous RAM, with load extension, read-modify-write sub-word stores and rejection of illegal requests.
module dmem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int RAM_AW = 12
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              resp_valid_o,
  output logic [31:0]       resp_rdata_o,
  output logic              err_misalign_o,
  output logic              stall_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i,
  output logic [2:0]        dbg_state_o
);

  // Handshake: a request transfers on a rising edge where req_valid_i & req_ready_o;
  // req_ready_o is high only in IDLE and the requester need not hold anything afterwards.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_RDATA = 3'd2,
    S_WR    = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  state_e              state_q;
  logic                we_q;
  logic [2:0]          funct3_q;
  logic [RAM_AW+1:0]   addr_q;
  logic [31:0]         wdata_q;

  logic                misalign;
  logic                bad_funct;
  logic                illegal;
  logic [31:0]         lane_shift;
  logic [7:0]          lane_b;
  logic [15:0]         lane_h;
  logic [31:0]         load_ext;
  logic [31:0]         merged;
  logic                unused_addr_bits;

  // Only the word-address window of the byte address reaches the RAM.
  assign unused_addr_bits = ^req_addr_i[ADDR_W-1:RAM_AW+2];

  // Request legality, evaluated on the live request inputs.
  always_comb begin
    misalign  = 1'b0;
    bad_funct = 1'b0;
    case (req_funct3_i[1:0])
      2'b01:   misalign = req_addr_i[0];
      2'b10:   misalign = |req_addr_i[1:0];
      default: misalign = 1'b0;
    endcase
    if (req_we_i) begin
      bad_funct = (req_funct3_i > 3'b010);
    end else begin
      bad_funct = (req_funct3_i == 3'b011) || (req_funct3_i[2:1] == 2'b11);
    end
    illegal = bad_funct | misalign;
  end

  // Lane extraction and extension of the word read back from the RAM.
  always_comb begin
    lane_shift = ram_rdata_i >> {addr_q[1:0], 3'b000};
    lane_b     = lane_shift[7:0];
    lane_h     = addr_q[1] ? ram_rdata_i[31:16] : ram_rdata_i[15:0];
    load_ext   = ram_rdata_i;
    case (funct3_q[1:0])
      2'b00:   load_ext = {{24{lane_b[7] & ~funct3_q[2]}}, lane_b};
      2'b01:   load_ext = {{16{lane_h[15] & ~funct3_q[2]}}, lane_h};
      default: load_ext = ram_rdata_i;
    endcase
  end

  always_comb begin
    merged = ram_rdata_i;
    if (funct3_q[0]) begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end else begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            we_q     <= req_we_i;
            funct3_q <= req_funct3_i;
            addr_q   <= req_addr_i[RAM_AW+1:0];
            wdata_q  <= req_wdata_i;
            if (illegal) begin
              state_q <= S_ERR;
            end else if (req_we_i && req_funct3_i == 3'b010) begin
              state_q <= S_WR;
            end else begin
              state_q <= S_RD;
            end
          end
        end
        S_RD: state_q <= S_RDATA;
        S_RDATA: begin
          if (we_q) begin
            // The merged word replaces the store data so WR always drives wdata_q.
            wdata_q <= merged;
            state_q <= S_WR;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WR:    state_q <= S_IDLE;
        S_ERR:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready_o    = (state_q == S_IDLE);
    ram_en_o       = (state_q == S_RD) || (state_q == S_WR);
    ram_we_o       = (state_q == S_WR);
    ram_addr_o     = ram_en_o ? addr_q[RAM_AW+1:2] : '0;
    ram_wdata_o    = ram_we_o ? wdata_q : 32'h0;
    err_misalign_o = (state_q == S_ERR);
    resp_valid_o   = ((state_q == S_RDATA) && !we_q) || (state_q == S_WR) || (state_q == S_ERR);
    resp_rdata_o   = ((state_q == S_RDATA) && !we_q) ? load_ext : 32'h0;
    stall_o        = (state_q == S_IDLE) ? req_valid_i : !resp_valid_o;
    dbg_state_o    = state_q;
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed and random loads/stores against a word-array memory model
// that applies the load/store rules directly, plus reset and reset-mid-access checks.
module tb_dmem_access_ctrl;

  logic        clk;
  logic        arst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        err_misalign_o;
  logic        stall_o;
  logic        ram_en_o;
  logic        ram_we_o;
  logic [11:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata;
  logic [2:0]  dbg_state;

  int passed = 0;
  int total  = 0;

  logic [31:0] ram_mem [0:4095];
  logic [31:0] ref_mem [0:4095];

  dmem_access_ctrl #(.ADDR_W(32), .RAM_AW(12)) dut (
    .clk(clk), .arst_n(arst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .err_misalign_o(err_misalign_o),
    .stall_o(stall_o), .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata), .dbg_state_o(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) ram_mem[ram_addr_o] <= ram_wdata_o;
      else          ram_rdata <= ram_mem[ram_addr_o];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic is_illegal(input logic we, input logic [2:0] f3, input logic [31:0] a);
    if (we) begin
      if (f3 == 3'd0) return 1'b0;
      if (f3 == 3'd1) return a[0];
      if (f3 == 3'd2) return a[1:0] != 2'b00;
      return 1'b1;
    end
    if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
    if (f3 == 3'd1 || f3 == 3'd5) return a[0];
    if (f3 == 3'd2) return a[1:0] != 2'b00;
    return 1'b1;
  endfunction

  // Driver + scoreboard for one request.
  task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
    logic [11:0] idx;
    logic [31:0] word, exp_rd, exp_wr, b, h, mask, got_rd, got_wr;
    int exp_lat, exp_en, exp_w, n, en_cnt, w_cnt, sh;
    logic ill, got, got_err, flag_stall, flag_bus, flag_busy;
    idx  = addr[13:2];
    word = ref_mem[idx];
    ill  = is_illegal(we, f3, addr);
    exp_rd = 32'h0;
    exp_wr = word;
    exp_w  = 0;
    if (ill) begin
      exp_lat = 1; exp_en = 0;
    end else if (!we) begin
      exp_lat = 2; exp_en = 1;
      b = (word >> (8 * int'(addr[1:0]))) & 32'hFF;
      h = (word >> (16 * int'(addr[1]))) & 32'hFFFF;
      case (f3)
        3'd0:    exp_rd = (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
        3'd1:    exp_rd = (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
        3'd4:    exp_rd = b;
        3'd5:    exp_rd = h;
        default: exp_rd = word;
      endcase
    end else if (f3 == 3'd2) begin
      exp_lat = 1; exp_en = 1; exp_w = 1; exp_wr = wdata;
    end else begin
      exp_lat = 3; exp_en = 2; exp_w = 1;
      sh   = (f3 == 3'd0) ? 8 * int'(addr[1:0]) : 16 * int'(addr[1]);
      mask = (f3 == 3'd0) ? 32'hFF : 32'hFFFF;
      exp_wr = (word & ~(mask << sh)) | ((wdata & mask) << sh);
    end

    @(negedge clk);
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_funct3_i = f3;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
    #1;
    chk({tag, ".ready"}, {31'd0, req_ready_o}, 32'd1);
    chk({tag, ".stall_req"}, {31'd0, stall_o}, 32'd1);
    @(posedge clk);
    #1;
    req_valid_i  = 1'b0;
    req_we_i     = 1'($urandom);
    req_funct3_i = 3'($urandom);
    req_addr_i   = $urandom;
    req_wdata_i  = $urandom;

    n = 0; en_cnt = 0; w_cnt = 0; got = 0; got_rd = 0; got_err = 0; got_wr = 0;
    flag_stall = 0; flag_bus = 0; flag_busy = 0;
    while (!got && n < 8) begin
      @(negedge clk);
      n++;
      if (ram_en_o) begin
        en_cnt++;
        if (ram_addr_o !== idx) flag_bus = 1;
        if (ram_we_o) begin
          w_cnt++;
          got_wr = ram_wdata_o;
        end
      end else if (ram_addr_o !== 12'd0 || ram_wdata_o !== 32'd0 || ram_we_o !== 1'b0) begin
        flag_bus = 1;
      end
      if (resp_valid_o) begin
        got = 1; got_rd = resp_rdata_o; got_err = err_misalign_o;
        if (stall_o !== 1'b0) flag_stall = 1;
      end else begin
        if (stall_o !== 1'b1) flag_stall = 1;
        if (err_misalign_o !== 1'b0 || resp_rdata_o !== 32'd0) flag_busy = 1;
      end
      if (req_ready_o !== 1'b0) flag_busy = 1;
    end
    chk({tag, ".latency"}, n, exp_lat);
    chk({tag, ".rdata"}, got_rd, exp_rd);
    chk({tag, ".err"}, {31'd0, got_err}, {31'd0, ill});
    chk({tag, ".ram_en_cycles"}, en_cnt, exp_en);
    chk({tag, ".ram_writes"}, w_cnt, exp_w);
    chk({tag, ".stall"}, {31'd0, flag_stall}, 32'd0);
    chk({tag, ".bus"}, {31'd0, flag_bus}, 32'd0);
    chk({tag, ".busy_outs"}, {31'd0, flag_busy}, 32'd0);
    if (exp_w == 1) begin
      chk({tag, ".wdata"}, got_wr, exp_wr);
      ref_mem[idx] = exp_wr;
    end
  endtask

  initial begin
    logic flag;
    logic [31:0] a;
    arst_n = 1'b0;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = 3'd0;
    req_addr_i = 32'd0; req_wdata_i = 32'd0;
    #1;
    chk("rst.ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst.outs", {resp_valid_o, err_misalign_o, stall_o, ram_en_o, ram_we_o, 27'd0}, 32'd0);
    chk("rst.data", resp_rdata_o | ram_wdata_o | {20'd0, ram_addr_o}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    flag = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (req_ready_o !== 1'b1 || stall_o !== 1'b0 || ram_en_o !== 1'b0 || resp_valid_o !== 1'b0) flag = 1;
    end
    chk("idle_after_reset", {31'd0, flag}, 32'd0);

    // Directed loads of a known word
    run_req("sw_40", 1'b1, 3'd2, 32'h40, 32'h8091A2B3);
    run_req("lb_43", 1'b0, 3'd0, 32'h43, 32'h0);
    run_req("lbu_42", 1'b0, 3'd4, 32'h42, 32'h0);
    run_req("lh_42", 1'b0, 3'd1, 32'h42, 32'h0);
    run_req("lhu_40", 1'b0, 3'd5, 32'h40, 32'h0);
    chk("lb_43.const", ((ref_mem[16] >> 24) & 32'hFF) | 32'hFFFFFF00, 32'hFFFFFF80);

    // Sub-word store as read-modify-write
    run_req("sw_50", 1'b1, 3'd2, 32'h50, 32'h11223344);
    run_req("sb_51", 1'b1, 3'd0, 32'h51, 32'h00000055);
    chk("sb_51.result", ref_mem[20], 32'h11225544);
    run_req("lw_50", 1'b0, 3'd2, 32'h50, 32'h0);

    run_req("sw_44", 1'b1, 3'd2, 32'h44, 32'hDEADBEEF);
    run_req("lw_44", 1'b0, 3'd2, 32'h44, 32'h0);

    // Rejected requests
    run_req("lw_42_err", 1'b0, 3'd2, 32'h42, 32'h0);
    run_req("sh_41_err", 1'b1, 3'd1, 32'h41, 32'h1234);
    run_req("ld_f3_011_err", 1'b0, 3'd3, 32'h40, 32'h0);
    run_req("st_f3_100_err", 1'b1, 3'd4, 32'h40, 32'h0);
    run_req("sw_46_err", 1'b1, 3'd2, 32'h46, 32'h0);

    // Address wrap: 0x4040 aliases word 0x40
    run_req("sw_4040", 1'b1, 3'd2, 32'h4040, 32'hCAFEF00D);
    run_req("lw_40_wrap", 1'b0, 3'd2, 32'h40, 32'h0);

    // Reset pulse during the RDATA cycle of an SH
    run_req("sw_48", 1'b1, 3'd2, 32'h48, 32'h0BADC0DE);
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = 3'd1;
    req_addr_i = 32'h4A; req_wdata_i = 32'h7777;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("rst_mid.rd_en", {31'd0, ram_en_o}, 32'd1);
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    chk("rst_mid.ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst_mid.outs", {resp_valid_o, ram_en_o, ram_we_o, err_misalign_o, 28'd0}, 32'd0);
    #1;
    arst_n = 1'b1;
    flag = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ram_en_o !== 1'b0 || resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) flag = 1;
    end
    chk("rst_mid.quiet", {31'd0, flag}, 32'd0);
    run_req("lw_48_after_rst", 1'b0, 3'd2, 32'h48, 32'h0);

    // Random phase over words 0..15, with random upper address bits
    for (int i = 0; i < 16; i++) begin
      a = ($urandom & 32'hFFFFC000) | (i << 2);
      run_req($sformatf("init%0d", i), 1'b1, 3'd2, a, $urandom);
    end
    for (int i = 0; i < 80; i++) begin
      a = ($urandom & 32'hFFFFC000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      run_req($sformatf("rnd%0d", i), 1'($urandom), 3'($urandom_range(0, 7)), a, $urandom);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
